// File: rtl/period_meter.sv
// Measures the clk-cycle distance between consecutive rising edges of an asynchronous input.
// The block reports each captured period with a valid pulse, and pulses timeout when edges stop arriving.
module period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  // state   | meaning
  // IDLE    | not measuring, counter held at 0
  // ARM     | waiting for the first rise that opens a period
  // MEASURE | counting between rises, capturing on each rise
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TC  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sync1, sync2, sync3;
  logic             rise;
  logic             cap;
  logic             tout_nx;

  assign rise = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Enable beats rise, and rise beats the timeout compare.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    cap      = 1'b0;
    tout_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (meas_en) state_nx = ARM;
      end
      ARM, MEASURE: begin
        if (!meas_en) begin
          state_nx = IDLE;
        end else if (rise) begin
          state_nx = MEASURE;
          cap      = (state == MEASURE);
        end else if (cnt == TC) begin
          state_nx = ARM;
          tout_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // cnt never exceeds TIMEOUT-1, so cnt+1 cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (cap) period <= cnt + ONE;
      period_valid <= cap;
      timeout      <= tout_nx;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: one instance with the default timeout, one with TIMEOUT=1000.
// Expected periods are queued as edges are driven and popped on each period_valid.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_a = 1'b0, en_a = 1'b0, sig_b = 1'b0, en_b = 1'b0;
  logic [15:0] period_a, period_b;
  logic        pv_a, pv_b, to_a, to_b, busy_a, busy_b;

  period_meter #(.CNT_W(16), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .meas_en(en_a),
    .period(period_a), .period_valid(pv_a), .timeout(to_a), .busy(busy_a)
  );

  period_meter #(.CNT_W(16), .TIMEOUT(1000)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .meas_en(en_b),
    .period(period_b), .period_valid(pv_b), .timeout(to_b), .busy(busy_b)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int per;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0, n_fail = 0;
  int   na_pv = 0, nb_pv = 0, nb_to = 0;
  int   next_to_b = 0;
  bit   to_ok_b = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Square wave of period p; rises at index >= skip close a period and are queued.
  task automatic gen(input bit which, input int p, input int n, input int skip);
    int hi;
    hi = p / 2;
    for (int i = 0; i < n; i++) begin
      if (which) sig_b = 1'b1;
      else       sig_a = 1'b1;
      if (i >= skip) begin
        if (which) qb.push_back('{per: p, cyc: cyc});
        else       qa.push_back('{per: p, cyc: cyc});
      end
      tick(hi);
      if (which) sig_b = 1'b0;
      else       sig_a = 1'b0;
      tick(p - hi);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pv_a) begin
      na_pv++;
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_period", period_a, e.per);
        chk("a_latency_le4", (cyc - e.cyc) <= 4, 1);
      end
    end
    if (to_a) chk("a_unexpected_timeout", 1, 0);
    if (pv_b) begin
      nb_pv++;
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_period", period_b, e.per);
        chk("b_latency_le4", (cyc - e.cyc) <= 4, 1);
      end
    end
    if (to_b) begin
      nb_to++;
      if (!to_ok_b) chk("b_unexpected_timeout", 1, 0);
      else begin
        chk("b_timeout_cycle", cyc, next_to_b);
        next_to_b += 1000;
      end
    end
  end

  initial begin
    #2 rst = 1'b0;
    #3;
    chk("rst_period_a", period_a, 0);
    chk("rst_valid_a", pv_a, 0);
    chk("rst_timeout_a", to_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_period_b", period_b, 0);
    chk("rst_busy_b", busy_b, 0);
    @(negedge clk) rst = 1'b1;
    tick(2);

    // 5000-cycle square wave; first capture only after the second rise
    en_a = 1'b1;
    tick(3);
    chk("a_busy_arm", busy_a, 1);
    gen(1'b0, 5000, 4, 1);
    sig_a = 1'b1;
    qa.push_back('{per: 5000, cyc: cyc});
    tick(2003);
    chk("a_valid_count_5000", na_pv, 4);

    // drop enable 2000 cycles after a capture
    en_a = 1'b0;
    tick(1);
    chk("a_busy_after_drop", busy_a, 0);
    chk("a_period_after_drop", period_a, 5000);
    tick(496);
    sig_a = 1'b0;
    gen(1'b0, 5000, 1, 1);
    chk("a_period_idle_hold", period_a, 5000);
    chk("a_valid_count_idle", na_pv, 4);

    // shortest period: 2 high, 2 low
    en_a = 1'b1;
    tick(5);
    gen(1'b0, 4, 10, 1);
    tick(10);
    chk("a_valid_count_p4", na_pv, 13);
    chk("a_period_p4", period_a, 4);

    // reset in the middle of a measurement
    en_a = 1'b0;
    tick(3);
    en_a = 1'b1;
    tick(3);
    gen(1'b0, 100, 3, 1);
    @(posedge clk);
    #5 rst = 1'b0;
    #1;
    chk("midrst_period_a", period_a, 0);
    chk("midrst_valid_a", pv_a, 0);
    chk("midrst_timeout_a", to_a, 0);
    chk("midrst_busy_a", busy_a, 0);
    @(negedge clk) rst = 1'b1;
    tick(2);
    chk("a_busy_after_rst", busy_a, 1);
    gen(1'b0, 100, 3, 1);
    tick(10);
    chk("a_valid_count_rst", na_pv, 17);
    chk("a_queue_empty", qa.size(), 0);
    en_a = 1'b0;

    // TIMEOUT=1000 with no edges
    to_ok_b = 1'b1;
    en_b = 1'b1;
    next_to_b = cyc + 1001;
    tick(3500);
    chk("b_timeout_count", nb_to, 3);
    chk("b_period_none", period_b, 0);
    chk("b_valid_none", nb_pv, 0);

    // period exactly TIMEOUT: rise wins over the timeout compare
    en_b = 1'b0;
    tick(3);
    to_ok_b = 1'b0;
    en_b = 1'b1;
    gen(1'b1, 1000, 5, 1);
    en_b = 1'b0;
    tick(10);
    chk("b_valid_count_1000", nb_pv, 4);
    chk("b_period_1000", period_b, 1000);
    chk("b_timeout_count_final", nb_to, 3);
    chk("b_queue_empty", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period counter and the period output.
REQ-002 Parameter TIMEOUT, default 65535: cycles without a rising edge before timeout; legal range 2..2^CNT_W-1.
REQ-003 clk  input  1  single system clock (50 MHz); all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sig_in  input  1  asynchronous signal being measured, e.g. a divided-clock output.
REQ-006 meas_en  input  1  synchronous enable; 1 = measure continuously, 0 = idle.
REQ-007 period  output  CNT_W  last captured period, in clk cycles between consecutive sig_in rising edges.
REQ-008 period_valid  output  1  one-cycle pulse; period was updated on the previous cycle.
REQ-009 timeout  output  1  one-cycle pulse when no rising edge arrives within TIMEOUT cycles.
REQ-010 busy  output  1  high when state is ARM or MEASURE.

Function
REQ-011 sig_in shall pass through a two-flop synchronizer; a third flop shall hold the previous synchronized value; rise = sync2 & ~sync3.
REQ-012 The FSM shall have exactly three states: IDLE, ARM, MEASURE.
REQ-013 IDLE: counter held at 0; meas_en=1 -> ARM on the next cycle.
REQ-014 ARM: counter increments each cycle; rise -> MEASURE with counter cleared to 0.
REQ-015 MEASURE: counter increments each cycle; on rise, the capture value is counter+1, and the counter clears to 0; state stays MEASURE.
REQ-016 On capture, period shall load the capture value, and period_valid shall pulse high on the following cycle for exactly one cycle.
REQ-017 A 5000-cycle sig_in period shall yield period = 5000, i.e. exactly the clk-cycle distance between the two detected rises.
REQ-018 In ARM or MEASURE, if counter = TIMEOUT-1 and rise is 0: pulse timeout for one cycle, clear counter, go to ARM; period is unchanged.
REQ-019 If rise and the timeout condition coincide in MEASURE: rise wins; capture with period = TIMEOUT; no timeout pulse.
REQ-020 meas_en=0 in ARM or MEASURE -> IDLE on the next cycle; counter cleared; no period_valid or timeout pulse; period retains its value.
REQ-021 meas_en has priority over rise and timeout in the same cycle.
REQ-022 The counter shall never wrap; TIMEOUT bounds it below 2^CNT_W.
REQ-023 Latency from the sig_in rising edge that closes a period to the period_valid pulse shall be at most 4 clk cycles and constant.
REQ-024 The first period_valid after entering ARM shall require two rises; the first rise only arms MEASURE.

Reset
REQ-025 rst=0 shall immediately force: state IDLE, counter 0, sync flops 0, period 0, period_valid 0, timeout 0, busy 0.
REQ-026 A reset mid-MEASURE shall discard the partial count; after release, measurement restarts from IDLE per REQ-013 and REQ-024.
REQ-027 All outputs shall be registered; none shall be combinational from sig_in or meas_en.

Verification
REQ-028 Scenario: 10 kHz square wave on sig_in (5000 clk period), meas_en=1 -> first period_valid after the second rise with period = 5000, then one pulse every 5000 cycles; timeout never asserts.
REQ-029 Scenario: TIMEOUT=1000, sig_in held 0, meas_en=1 -> timeout pulses every 1000 cycles; period_valid never asserts; period stays 0.
REQ-030 Scenario: sig_in period 4 (2 high, 2 low) -> period = 4 on every pulse, period_valid every 4 cycles.
REQ-031 Scenario: meas_en dropped 2000 cycles after a capture of 5000 -> busy=0 next cycle; no pulse; period remains 5000.
REQ-032 Scenario: TIMEOUT=1000, sig_in period exactly 1000 -> period = 1000 each pulse; timeout never asserts.
REQ-033 Scenario: rst=0 asynchronously mid-MEASURE -> all outputs 0 within the same cycle; after release, first period_valid occurs only after two new rises.
